incr_sched: RTL and testbench
=============================

# incr_sched

Round-robin scheduler that shares one external incrementer datapath among `NUM_REQ` requesters. It accepts operands over per-requester valid/ready handshakes and issues them to the incrementer one per cycle. Each result is routed back to the requester that issued it, using an internal in-order tag FIFO. It sits between the requester ports and the `incr` datapath, and the incr bench environment drives it.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `W`, 8: operand/result width.
- `DEPTH`, 4: maximum outstanding operations (tag FIFO depth, power of 2).

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `reset`, input, 1: synchronous, active-high reset.
- `en`, input, 1: when 0, no new grants are made; in-flight results still drain.
- `req_valid`, input, `NUM_REQ`: requester i has an operand.
- `req_data`, input, `NUM_REQ*W`: operand of requester i at bits `[i*W +: W]`.
- `req_ready`, output, `NUM_REQ`: one-hot grant, combinational in the same cycle.
- `inc_in_valid`, output, 1: issue strobe to the incrementer (registered).
- `inc_in_data`, output, `W`: operand to the incrementer (registered).
- `inc_out_valid`, input, 1: incrementer result strobe; latency is arbitrary but results return in order.
- `inc_out_data`, input, `W`: incrementer result.
- `rsp_valid`, output, `NUM_REQ`: one-hot, one-cycle result strobe (registered).
- `rsp_data`, output, `W`: result, valid with any `rsp_valid` bit.
- `rsp_id`, output, `$clog2(NUM_REQ)`: index of the destination requester.
- `outstanding`, output, `$clog2(DEPTH+1)`: number of issued but unreturned operations.
- `err_unexpected`, output, 1: sticky; set on `inc_out_valid` while `outstanding` is 0.

## Operation
- **RR pointer.** `ptr` (0..NUM_REQ-1) marks the highest-priority requester. The grant goes to the first i in the order ptr, ptr+1, … (mod NUM_REQ) with `req_valid[i]` = 1.
- **Grant conditions.** A grant is made only when all of the following hold:
  - `en` = 1 and `reset` = 0;
  - the FIFO can accept a push: `outstanding` < `DEPTH`, or a pop happens in the same cycle (`inc_out_valid` = 1 with `outstanding` > 0).
- **On handshake** (`req_valid[g]` & `req_ready[g]`):
  - push tag g into the FIFO;
  - latch `req_data[g]` into `inc_in_data` and set `inc_in_valid` = 1 on the next cycle;
  - set `ptr` to (g+1) mod NUM_REQ.
- **Pointer hold.** `ptr` is unchanged when there is no handshake.
- **Issue width.** At most one issue per cycle. `inc_in_valid` is 0 in any cycle not preceded by a handshake.
- **On `inc_out_valid` with `outstanding` > 0:**
  - pop tag t;
  - on the next cycle: `rsp_valid` = 1 << t, `rsp_data` = `inc_out_data`, `rsp_id` = t.
- **On `inc_out_valid` with `outstanding` = 0:**
  - the result is dropped and `err_unexpected` is set;
  - `err_unexpected` clears only on `reset`;
  - `outstanding` stays 0, with no underflow.
- **`outstanding` update.** `outstanding` is +1 on a push only, −1 on a pop only, and unchanged on a simultaneous push and pop. It never exceeds `DEPTH`.
- **Data path.** Result data passes through unmodified, with no width change. Wrap-around such as 0xFF→0x00 is the datapath's business.
- **`en` deassertion.** Lowering `en` never cancels an in-flight operation.

## Timing
- Grant is combinational from `req_valid`, `en`, `outstanding`, `inc_out_valid` and `ptr`.
- Request handshake in cycle N gives `inc_in_valid` in cycle N+1.
- `inc_out_valid` in cycle M gives `rsp_valid` in cycle M+1.
- End-to-end latency is incrementer latency + 2 cycles.
- Requesters may not retract `req_valid` or change `req_data` until they see `req_ready`. The scheduler may hold `req_ready` low for an arbitrary time.
- Reset values, applied on the first rising edge with `reset` = 1:
  - outputs: `req_ready` = 0, `inc_in_valid` = 0, `inc_in_data` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `outstanding` = 0, `err_unexpected` = 0;
  - internal state: `ptr` = 0, FIFO empty.
- Reset mid-operation discards all tags. Results arriving after reset with `outstanding` = 0 set `err_unexpected`. The bench must flush the datapath together with the scheduler.
- Simultaneous full push and pop are legal. A pop and a push in the same cycle at `outstanding` = `DEPTH` keeps `outstanding` = `DEPTH`.

## Test plan
- **Single requester.** Requester 2 sends 0x41; the bench incrementer uses 3-cycle latency. Expect `inc_in_data` = 0x41 one cycle after the handshake, then `rsp_valid` = 4'b0100, `rsp_data` = 0x42, `rsp_id` = 2 at 5 cycles after the handshake.
- **Round-robin fairness.** All 4 requesters hold `req_valid` continuously with data 0x10..0x13, `DEPTH` = 4, 1-cycle incrementer. Expect grant order 0,1,2,3,0,… and responses 0x11..0x14 to ids 0..3 in order.
- **Full / backpressure.** Hold the bench incrementer results for 10 cycles after 4 issues. Expect `outstanding` = 4 and `req_ready` = 0. The first returned result re-enables a grant in the same cycle, and `outstanding` stays 4.
- **Wrap-around data.** Requester 1 sends 0xFF. Expect `rsp_data` = 0x00, `rsp_id` = 1, `err_unexpected` = 0.
- **Unexpected result.** Pulse `inc_out_valid` with `outstanding` = 0. Expect `err_unexpected` = 1, no `rsp_valid`, and `outstanding` = 0; the flag stays 1 until `reset`.
- **Reset and `en`.**
  - Assert `reset` with 3 operations outstanding. Next cycle, expect all outputs at their reset values and `ptr` = 0.
  - With `en` = 0 and `req_valid` = 4'b1111, expect `req_ready` = 0 while already-issued results still produce `rsp_valid`.

Source files
------------

// File: rtl/incr_sched.sv
// incr_sched: round-robin scheduler sharing one incrementer datapath among NUM_REQ requesters.
// Results are routed back to their issuer through an in-order tag FIFO of DEPTH entries.
module incr_sched #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*W-1:0]         req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         inc_in_valid,
    output logic [W-1:0]                 inc_in_data,
    input  logic                         inc_out_valid,
    input  logic [W-1:0]                 inc_out_data,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [W-1:0]                 rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         err_unexpected
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int OCW = $clog2(DEPTH+1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDW-1:0]     ptr_r;
    logic [IDW-1:0]     tag_mem_r [DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [OCW-1:0]     outstanding_r;
    logic               inc_in_valid_r;
    logic [W-1:0]       inc_in_data_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [W-1:0]       rsp_data_r;
    logic [IDW-1:0]     rsp_id_r;
    logic               err_unexpected_r;

    logic               grant_found_s;
    logic [IDW-1:0]     grant_idx_s;
    logic [IDW:0]       rr_sum_s;
    logic [IDW-1:0]     rr_cand_s;
    logic               pop_s;
    logic               can_push_s;
    logic               grant_s;
    logic [W-1:0]       operand_s;
    logic [IDW-1:0]     pop_tag_s;

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [IDW-1:0] id);
        logic [NUM_REQ-1:0] vec;
        vec     = {NUM_REQ{1'b0}};
        vec[id] = 1'b1;
        return vec;
    endfunction

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        logic [IDW-1:0] nxt;
        if (id == IDW'(NUM_REQ-1)) begin
            nxt = {IDW{1'b0}};
        end else begin
            nxt = id + IDW'(1);
        end
        return nxt;
    endfunction

    function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] slot);
        logic [PW-1:0] nxt;
        if (slot == PW'(DEPTH-1)) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = slot + PW'(1);
        end
        return nxt;
    endfunction

    // Round-robin search: first valid requester at or after ptr_r, modulo NUM_REQ.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {IDW{1'b0}};
        rr_sum_s      = {(IDW+1){1'b0}};
        rr_cand_s     = {IDW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum_s  = {1'b0, ptr_r} + (IDW+1)'(k);
            rr_cand_s = (rr_sum_s >= (IDW+1)'(NUM_REQ)) ? IDW'(rr_sum_s - (IDW+1)'(NUM_REQ))
                                                        : IDW'(rr_sum_s);
            if (!grant_found_s && req_valid[rr_cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = rr_cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still accept a grant.
    assign pop_s      = inc_out_valid && (outstanding_r != {OCW{1'b0}});
    assign can_push_s = (outstanding_r < OCW'(DEPTH)) || pop_s;
    assign grant_s    = en && !reset && can_push_s && grant_found_s;
    assign operand_s  = req_data[grant_idx_s*W +: W];
    assign pop_tag_s  = tag_mem_r[rd_ptr_r];
    assign req_ready  = grant_s ? id_onehot(grant_idx_s) : {NUM_REQ{1'b0}};

    // Issue register, tag FIFO, response register and outstanding counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r            <= {IDW{1'b0}};
            wr_ptr_r         <= {PW{1'b0}};
            rd_ptr_r         <= {PW{1'b0}};
            outstanding_r    <= {OCW{1'b0}};
            inc_in_valid_r   <= 1'b0;
            inc_in_data_r    <= {W{1'b0}};
            rsp_valid_r      <= {NUM_REQ{1'b0}};
            rsp_data_r       <= {W{1'b0}};
            rsp_id_r         <= {IDW{1'b0}};
            err_unexpected_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_r[i] <= {IDW{1'b0}};
            end
        end else begin
            inc_in_valid_r <= grant_s;
            if (grant_s) begin
                inc_in_data_r       <= operand_s;
                tag_mem_r[wr_ptr_r] <= grant_idx_s;
                wr_ptr_r            <= next_slot(wr_ptr_r);
                ptr_r               <= next_id(grant_idx_s);
            end
            rsp_valid_r <= pop_s ? id_onehot(pop_tag_s) : {NUM_REQ{1'b0}};
            if (pop_s) begin
                rsp_data_r <= inc_out_data;
                rsp_id_r   <= pop_tag_s;
                rd_ptr_r   <= next_slot(rd_ptr_r);
            end
            // A result with nothing outstanding is dropped and flagged until reset.
            if (inc_out_valid && !pop_s) begin
                err_unexpected_r <= 1'b1;
            end
            case ({grant_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + OCW'(1);
                2'b01:   outstanding_r <= outstanding_r - OCW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    assign inc_in_valid   = inc_in_valid_r;
    assign inc_in_data    = inc_in_data_r;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_data       = rsp_data_r;
    assign rsp_id         = rsp_id_r;
    assign outstanding    = outstanding_r;
    assign err_unexpected = err_unexpected_r;
endmodule

// File: tb/tb_incr_sched.sv
// tb_incr_sched: directed and randomized checks of incr_sched against a queue-based reference model,
// with a behavioural in-order incrementer of programmable latency.
module tb_incr_sched;
    localparam int NR    = 4;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [NR-1:0]     req_valid;
    logic [NR*W-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic              inc_in_valid;
    logic [W-1:0]      inc_in_data;
    logic              inc_out_valid;
    logic [W-1:0]      inc_out_data;
    logic [NR-1:0]     rsp_valid;
    logic [W-1:0]      rsp_data;
    logic [1:0]        rsp_id;
    logic [2:0]        outstanding;
    logic              err_unexpected;

    always #5 clk = ~clk;

    incr_sched #(.NUM_REQ(NR), .W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .inc_in_valid(inc_in_valid), .inc_in_data(inc_in_data),
        .inc_out_valid(inc_out_valid), .inc_out_data(inc_out_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .outstanding(outstanding), .err_unexpected(err_unexpected)
    );

    typedef struct { logic [W-1:0] data; int due; } pend_t;
    typedef struct { int id; logic [W-1:0] operand; } tag_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic         en_v, reset_v, hold_v, inject_v;
    logic [W-1:0] inject_data_v;
    int           lat_v;
    logic [W-1:0] rq [NR][$];
    pend_t        pend [$];

    tag_t         mq [$];
    int           m_ptr;
    logic         m_err;
    logic [NR-1:0] obs_ready;

    int           hs_cyc [$];
    int           hs_id [$];
    int           ii_cyc [$];
    logic [W-1:0] ii_data [$];
    int           rs_cyc [$];
    int           rs_id [$];
    logic [NR-1:0] rs_vec [$];
    logic [W-1:0] rs_data [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        hs_cyc.delete(); hs_id.delete(); ii_cyc.delete(); ii_data.delete();
        rs_cyc.delete(); rs_id.delete(); rs_vec.delete(); rs_data.delete();
    endtask

    function automatic int busy();
        int n;
        n = mq.size() + pend.size();
        for (int i = 0; i < NR; i++) n += rq[i].size();
        return n;
    endfunction

    // One clock cycle: drive requesters and incrementer, predict, compare.
    task automatic run_cycle();
        logic [NR-1:0]   rv;
        logic [NR*W-1:0] rd;
        logic            iov, pop, can, found, grant;
        logic [W-1:0]    iod, exp_data;
        logic [NR-1:0]   exp_ready, exp_rsp;
        int              g;
        tag_t            t;
        rv = '0; rd = '0;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                rv[i] = 1'b1;
                rd[i*W +: W] = rq[i][0];
            end
        end
        iov = 1'b0; iod = '0;
        if (reset_v) pend.delete();
        if (inject_v) begin
            iov = 1'b1; iod = inject_data_v;
        end else if (!hold_v && !reset_v && pend.size() > 0 && pend[0].due <= cyc) begin
            iov = 1'b1; iod = pend[0].data + 8'd1; pend.delete(0);
        end
        reset = reset_v; en = en_v; req_valid = rv; req_data = rd;
        inc_out_valid = iov; inc_out_data = iod;
        #3;
        obs_ready = req_ready;
        pop   = iov && (mq.size() > 0) && !reset_v;
        can   = (mq.size() < DEPTH) || pop;
        found = 1'b0; g = 0;
        for (int k = 0; k < NR; k++) begin
            int c;
            c = (m_ptr + k) % NR;
            if (!found && rv[c]) begin found = 1'b1; g = c; end
        end
        grant = en_v && !reset_v && can && found;
        exp_ready = grant ? (NR'(1) << g) : '0;
        check("req_ready", obs_ready, exp_ready);
        for (int i = 0; i < NR; i++) begin
            if (obs_ready[i]) begin hs_cyc.push_back(cyc); hs_id.push_back(i); end
        end
        @(posedge clk); #1;
        if (reset_v) begin
            mq.delete(); m_ptr = 0; m_err = 1'b0;
            check("rst_inc_in_valid", inc_in_valid, 0);
            check("rst_inc_in_data", inc_in_data, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_rsp_id", rsp_id, 0);
            check("rst_outstanding", outstanding, 0);
            check("rst_err", err_unexpected, 0);
            check("rst_req_ready", req_ready, 0);
        end else begin
            exp_rsp = '0; exp_data = '0; t = '{id: 0, operand: '0};
            if (pop) begin
                t = mq.pop_front();
                exp_rsp  = NR'(1) << t.id;
                exp_data = t.operand + 8'd1;
            end
            if (iov && !pop) m_err = 1'b1;
            if (grant) begin
                mq.push_back('{id: g, operand: rd[g*W +: W]});
                m_ptr = (g + 1) % NR;
                rq[g].delete(0);
            end
            check("inc_in_valid", inc_in_valid, grant);
            if (grant) check("inc_in_data", inc_in_data, rd[g*W +: W]);
            check("rsp_valid", rsp_valid, exp_rsp);
            if (pop) begin
                check("rsp_data", rsp_data, exp_data);
                check("rsp_id", rsp_id, t.id);
            end
            check("outstanding", outstanding, mq.size());
            check("err_unexpected", err_unexpected, m_err);
        end
        if (inc_in_valid === 1'b1) begin
            ii_cyc.push_back(cyc + 1); ii_data.push_back(inc_in_data);
            pend.push_back('{data: inc_in_data, due: cyc + 1 + lat_v});
        end
        if (rsp_valid !== '0) begin
            rs_cyc.push_back(cyc + 1); rs_id.push_back(int'(rsp_id));
            rs_vec.push_back(rsp_valid); rs_data.push_back(rsp_data);
        end
        cyc++;
    endtask

    task automatic reset_pulse();
        reset_v = 1'b1;
        run_cycle();
        reset_v = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (busy() > 0 && n < budget) begin
            run_cycle();
            n++;
        end
        check("drain_done", busy(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        en_v = 1'b1; reset_v = 1'b1; hold_v = 1'b0; inject_v = 1'b0;
        inject_data_v = '0; lat_v = 3; m_ptr = 0; m_err = 1'b0;
        run_cycle();
        run_cycle();
        reset_v = 1'b0;

        // Single requester, 3-cycle incrementer
        clear_logs();
        rq[2].push_back(8'h41);
        drain(30);
        check("single_hs_n", hs_id.size(), 1);
        check("single_ii_n", ii_data.size(), 1);
        check("single_rs_n", rs_id.size(), 1);
        if (hs_id.size() == 1 && ii_data.size() == 1 && rs_id.size() == 1) begin
            check("single_hs_id", hs_id[0], 2);
            check("single_ii_data", ii_data[0], 8'h41);
            check("single_ii_lat", ii_cyc[0] - hs_cyc[0], 1);
            check("single_rsp_vec", rs_vec[0], 4'b0100);
            check("single_rsp_data", rs_data[0], 8'h42);
            check("single_rsp_id", rs_id[0], 2);
            check("single_rsp_lat", rs_cyc[0] - hs_cyc[0], 5);
        end

        // Round-robin fairness, 1-cycle incrementer
        reset_pulse();
        lat_v = 1;
        clear_logs();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) rq[i].push_back(8'(16 + i));
        drain(40);
        check("rr_hs_n", hs_id.size(), 8);
        check("rr_rs_n", rs_id.size(), 8);
        if (hs_id.size() == 8 && rs_id.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check("rr_grant_order", hs_id[k], k % NR);
                check("rr_rsp_id", rs_id[k], k % NR);
                check("rr_rsp_data", rs_data[k], 8'(17 + (k % NR)));
            end
        end

        // Full FIFO with results held back
        reset_pulse();
        hold_v = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NR; i++) rq[i].push_back(8'(32 + 4 * r + i));
        repeat (4) run_cycle();
        repeat (10) run_cycle();
        check("full_outstanding", outstanding, 4);
        check("full_ready", obs_ready, 4'b0000);
        hold_v = 1'b0;
        run_cycle();
        check("full_regrant", obs_ready, 4'b0001);
        check("full_outstanding_kept", outstanding, 4);
        drain(80);

        // Wrap-around data
        reset_pulse();
        lat_v = 2;
        clear_logs();
        rq[1].push_back(8'hFF);
        drain(30);
        check("wrap_rs_n", rs_id.size(), 1);
        if (rs_id.size() == 1) begin
            check("wrap_rsp_data", rs_data[0], 8'h00);
            check("wrap_rsp_id", rs_id[0], 1);
        end
        check("wrap_err", err_unexpected, 0);

        // Unexpected result with nothing outstanding
        inject_v = 1'b1; inject_data_v = 8'h55;
        run_cycle();
        inject_v = 1'b0;
        check("unexp_err", err_unexpected, 1);
        check("unexp_rsp_valid", rsp_valid, 4'b0000);
        check("unexp_outstanding", outstanding, 0);
        repeat (5) run_cycle();
        check("unexp_err_sticky", err_unexpected, 1);

        // Reset with three operations in flight
        lat_v = 8;
        rq[0].push_back(8'h01); rq[1].push_back(8'h02); rq[2].push_back(8'h03);
        repeat (3) run_cycle();
        check("mid_outstanding", outstanding, 3);
        check("mid_err_still_set", err_unexpected, 1);
        reset_pulse();
        for (int i = 0; i < NR; i++) begin
            rq[i].delete();
            rq[i].push_back(8'(64 + i));
        end
        run_cycle();
        check("post_rst_ptr0", obs_ready, 4'b0001);
        drain(60);

        // en low: no grants, in-flight results still drain
        lat_v = 3;
        rq[1].push_back(8'h71); rq[2].push_back(8'h72);
        repeat (2) run_cycle();
        en_v = 1'b0;
        for (int i = 0; i < NR; i++)
            if (rq[i].size() == 0) rq[i].push_back(8'(128 + i));
        clear_logs();
        repeat (8) run_cycle();
        check("en0_no_grants", hs_id.size(), 0);
        check("en0_rsp_drained", rs_id.size(), 2);
        en_v = 1'b1;
        drain(60);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            en_v    = ($urandom_range(0, 9) != 0);
            hold_v  = ($urandom_range(0, 4) == 0);
            reset_v = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 49) == 0) lat_v = $urandom_range(1, 5);
            for (int i = 0; i < NR; i++)
                if (rq[i].size() == 0 && $urandom_range(0, 2) != 0)
                    rq[i].push_back(8'($urandom_range(0, 255)));
            run_cycle();
        end
        en_v = 1'b1; hold_v = 1'b0; reset_v = 1'b0;
        drain(200);
        check("final_outstanding", outstanding, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
